// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control slice:
// state enum, opcode/funct constants, datapath mux encodings and decode helpers.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_RTYPE    = 4'd2,
        S_ALU_WB   = 4'd3,
        S_JR       = 4'd4,
        S_IMM      = 4'd5,
        S_IMM_WB   = 4'd6,
        S_LUI      = 4'd7,
        S_MEM_ADDR = 4'd8,
        S_MEM_RD   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_JAL      = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20, OP_LH   = 6'h21, OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24, OP_LHU  = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SH   = 6'h29, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_RTYPE = 3'd2, ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4, ALU_XOR = 3'd5, ALU_SLT   = 3'd6, ALU_SLTU = 3'd7;

    localparam logic [1:0] PC_ALU = 2'd0, PC_ALUOUT = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3;
    localparam logic [1:0] A_PC = 2'd0, A_RS = 2'd1, A_ZERO = 2'd2;
    localparam logic [2:0] B_RT = 3'd0, B_FOUR = 3'd1, B_IMM = 3'd2, B_IMMSH2 = 3'd3, B_LUI = 3'd4;
    localparam logic [1:0] WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2;
    localparam logic [1:0] RD_RT = 2'd0, RD_RD = 2'd1, RD_RA = 2'd2;
    localparam logic [1:0] SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2;

    function automatic logic isValidFunct(input logic [5:0] f);
        case (f)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic isLoad(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic isStore(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [1:0] memSize(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic memSignExt(input logic [5:0] op);
        return !((op == OP_LBU) || (op == OP_LHU));
    endfunction

    function automatic logic [2:0] immAluOp(input logic [5:0] op);
        case (op)
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            default:  return ALU_ADD;
        endcase
    endfunction

    // Logical immediates are zero-extended; arithmetic and compares sign-extend.
    function automatic logic immSignExt(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) || (op == OP_SLTIU);
    endfunction

    function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_RTYPE) begin
            if (!isValidFunct(fn)) return S_TRAP;
            return (fn == FN_JR) ? S_JR : S_RTYPE;
        end
        if (op == OP_J)                      return S_JUMP;
        if (op == OP_JAL)                    return S_JAL;
        if (op == OP_BEQ || op == OP_BNE)    return S_BRANCH;
        if (op >= OP_ADDI && op <= OP_XORI)  return S_IMM;
        if (op == OP_LUI)                    return S_LUI;
        if (isLoad(op) || isStore(op))       return S_MEM_ADDR;
        return S_TRAP;
    endfunction

endpackage

// File: rtl/mips_mc_memwait.sv
// Wait-state tracker for the shared memory port: flags access completion and
// a request left unacknowledged for MEM_TIMEOUT cycles.
module mips_mc_memwait #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ack,
    output logic done,
    output logic timeout
);

    logic [7:0] waitCnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (!active || mem_ack) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + 8'd1;
        end
    end

    assign done = active & mem_ack;
    // Fires on the waiting cycle that brings the count up to MEM_TIMEOUT.
    assign timeout = active & ~mem_ack & (waitCnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/mem/writeback over a
// shared req/ack memory port, traps on illegal opcodes and timeouts, counts retirements.
module mips_mc_ctrl
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic [1:0]       sig_size,
    output logic             ext_type,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       dbgState
);

    state_t state;
    logic   rstDone;
    logic   live;
    logic   memDone;
    logic   memTimeout;
    logic   retire;

    // Outputs stay quiet while reset is held and for the first cycle after release.
    assign live     = rstDone & rst;
    assign trap     = (state == S_TRAP);
    assign dbgState = state;

    mips_mc_memwait #(.MEM_TIMEOUT(MEM_TIMEOUT)) uWait (
        .clk     (clk),
        .rst     (rst),
        .active  (mem_req),
        .mem_ack (mem_ack),
        .done    (memDone),
        .timeout (memTimeout)
    );

    always_comb begin
        case (state)
            S_ALU_WB, S_IMM_WB, S_MEM_WB, S_JR, S_JUMP, S_JAL, S_BRANCH: retire = 1'b1;
            S_MEM_WR: retire = memDone;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_FETCH;
            rstDone <= 1'b0;
            instret <= '0;
        end else begin
            rstDone <= 1'b1;
            if (retire) instret <= instret + {{(CNT_W-1){1'b0}}, 1'b1};
            case (state)
                S_FETCH: begin
                    if (memTimeout)   state <= S_TRAP;
                    else if (memDone) state <= S_DECODE;
                end
                S_DECODE:   state <= dispatch(opcode, funct);
                S_RTYPE:    state <= S_ALU_WB;
                S_IMM:      state <= S_IMM_WB;
                S_LUI:      state <= S_IMM_WB;
                S_MEM_ADDR: state <= isLoad(opcode) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (memTimeout)   state <= S_TRAP;
                    else if (memDone) state <= S_MEM_WB;
                end
                S_MEM_WR: begin
                    if (memTimeout)   state <= S_TRAP;
                    else if (memDone) state <= S_FETCH;
                end
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        sig_size  = SZ_WORD;
        ext_type  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_ALU;
        alu_src_a = A_PC;
        alu_src_b = B_RT;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        reg_dst   = RD_RT;
        wb_sel    = WB_ALUOUT;
        if (live) begin
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = B_FOUR;
                    ir_we     = mem_ack;
                    pc_we     = mem_ack;
                end
                S_DECODE: begin
                    alu_src_b = B_IMMSH2;
                    ext_type  = 1'b1;
                end
                S_RTYPE: begin
                    alu_src_a = A_RS;
                    alu_op    = ALU_RTYPE;
                end
                S_ALU_WB: begin
                    reg_we  = 1'b1;
                    reg_dst = RD_RD;
                end
                S_JR: begin
                    pc_we  = 1'b1;
                    pc_src = PC_RS;
                end
                S_IMM: begin
                    alu_src_a = A_RS;
                    alu_src_b = B_IMM;
                    alu_op    = immAluOp(opcode);
                    ext_type  = immSignExt(opcode);
                end
                S_IMM_WB: reg_we = 1'b1;
                S_LUI: begin
                    alu_src_a = A_ZERO;
                    alu_src_b = B_LUI;
                end
                S_MEM_ADDR: begin
                    alu_src_a = A_RS;
                    alu_src_b = B_IMM;
                    ext_type  = 1'b1;
                end
                // Wait states repeat the address computation so ALUOut holds still.
                S_MEM_RD: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    sig_size  = memSize(opcode);
                    ext_type  = memSignExt(opcode);
                    alu_src_a = A_RS;
                    alu_src_b = B_IMM;
                end
                S_MEM_WB: begin
                    reg_we   = 1'b1;
                    wb_sel   = WB_MDR;
                    sig_size = memSize(opcode);
                    ext_type = memSignExt(opcode);
                end
                S_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    iord      = 1'b1;
                    sig_size  = memSize(opcode);
                    ext_type  = memSignExt(opcode);
                    alu_src_a = A_RS;
                    alu_src_b = B_IMM;
                end
                S_BRANCH: begin
                    alu_src_a = A_RS;
                    alu_op    = ALU_SUB;
                    pc_src    = PC_ALUOUT;
                    pc_we     = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = PC_JUMP;
                end
                S_JAL: begin
                    pc_we   = 1'b1;
                    pc_src  = PC_JUMP;
                    reg_we  = 1'b1;
                    reg_dst = RD_RA;
                    wb_sel  = WB_PC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: the driver queues hand-computed output snapshots,
// the monitor pops and compares whenever the controller strobes or a probe is raised.
module tb_mips_mc_ctrl;
    import mips_mc_pkg::*;

    localparam int W = 36;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ack;
    logic        mem_req, mem_we, iord, ext_type, ir_we, pc_we, reg_we, trap;
    logic [1:0]  sig_size, pc_src, alu_src_a, reg_dst, wb_sel;
    logic [2:0]  alu_src_b, alu_op;
    logic [31:0] instret;
    logic [3:0]  dbgState;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         probe;
    logic         trapPrev;
    int           checks;
    int           failures;

    mips_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .sig_size(sig_size), .ext_type(ext_type), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .trap(trap), .instret(instret), .dbgState(dbgState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: one snapshot per strobe cycle, trap rise, or probed cycle
    initial begin
        checks   = 0;
        failures = 0;
        trapPrev = 1'b0;
    end

    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        string        nm;
        act = {dbgState, mem_req, mem_we, iord, sig_size, ext_type, ir_we, pc_we,
               pc_src, alu_src_a, alu_src_b, alu_op, reg_we, reg_dst, wb_sel,
               trap, instret[7:0]};
        if (probe === 1'b1 || mem_req === 1'b1 || ir_we === 1'b1 || pc_we === 1'b1 ||
            reg_we === 1'b1 || (trap === 1'b1 && trapPrev !== 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got=%h want=<none>", act);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s got=%h want=%h", nm, act, e);
                end
            end
        end
        trapPrev = trap;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic expv(input string nm, input logic [3:0] st,
                        input logic req, input logic we, input logic io,
                        input logic [1:0] sz, input logic ext,
                        input logic irw, input logic pcw, input logic [1:0] pcs,
                        input logic [1:0] as, input logic [2:0] bs, input logic [2:0] op,
                        input logic rw, input logic [1:0] rd, input logic [1:0] wb,
                        input logic tr, input logic [7:0] cnt);
        exp_q.push_back({st, req, we, io, sz, ext, irw, pcw, pcs, as, bs, op, rw, rd, wb, tr, cnt});
        name_q.push_back(nm);
        probe = 1'b1;
    endtask

    task automatic expIdle(input string nm, input logic [3:0] st, input logic tr,
                           input logic [7:0] cnt);
        expv(nm, st, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0, 0, 2'd0, 2'd0, tr, cnt);
    endtask

    task automatic expFetch(input string nm, input logic ack, input logic [7:0] cnt);
        expv(nm, S_FETCH, 1, 0, 0, 2'd0, 0, ack, ack, 2'd0, 2'd0, 3'd1, 3'd0, 0, 2'd0, 2'd0, 0, cnt);
    endtask

    task automatic expMemAddr(input string nm, input logic [7:0] cnt);
        expv(nm, S_MEM_ADDR, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'd1, 3'd2, 3'd0, 0, 2'd0, 2'd0, 0, cnt);
    endtask

    task automatic fetchDecode(input string nm, input logic [5:0] op, input logic [5:0] fn,
                               input logic [7:0] cnt);
        opcode  = op;
        funct   = fn;
        mem_ack = 1'b1;
        expFetch({nm, "_fetch"}, 1'b1, cnt);
        tick();
        expv({nm, "_decode"}, S_DECODE, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'd0, 3'd3, 3'd0,
             0, 2'd0, 2'd0, 0, cnt);
        tick();
    endtask

    task automatic runAdd(input string nm, input logic [7:0] cnt);
        fetchDecode(nm, 6'h00, 6'h20, cnt);
        expv({nm, "_rtype"}, S_RTYPE, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 3'd0, 3'd2,
             0, 2'd0, 2'd0, 0, cnt);
        tick();
        expv({nm, "_wb"}, S_ALU_WB, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0,
             1, 2'd1, 2'd0, 0, cnt);
        tick();
    endtask

    task automatic runBranch(input string nm, input logic [5:0] op, input logic z,
                             input logic taken, input logic [7:0] cnt);
        fetchDecode(nm, op, 6'h00, cnt);
        zero = z;
        expv({nm, "_exec"}, S_BRANCH, 0, 0, 0, 2'd0, 0, 0, taken, 2'd1, 2'd1, 3'd0, 3'd1,
             0, 2'd0, 2'd0, 0, cnt);
        tick();
        zero = 1'b0;
    endtask

    task automatic doReset(input string nm);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        expIdle(nm, S_FETCH, 1'b0, 8'd0);
        tick();
    endtask

    initial begin
        rst     = 1'b0;
        mem_ack = 1'b0;
        zero    = 1'b0;
        opcode  = 6'h00;
        funct   = 6'h00;
        probe   = 1'b0;
        repeat (3) tick();
        expIdle("reset_hold", S_FETCH, 1'b0, 8'd0);
        tick();
        rst     = 1'b1;
        mem_ack = 1'b1;
        expIdle("ack_without_req", S_FETCH, 1'b0, 8'd0);
        tick();

        runAdd("add", 8'd0);

        // lw with three wait states
        fetchDecode("lw", 6'h23, 6'h04, 8'd1);
        expMemAddr("lw_addr", 8'd1);
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ack = 1'b1;
            expv("lw_wait", S_MEM_RD, 1, 0, 1, 2'd0, 1, 0, 0, 2'd0, 2'd1, 3'd2, 3'd0,
                 0, 2'd0, 2'd0, 0, 8'd1);
            tick();
        end
        expv("lw_wb", S_MEM_WB, 0, 0, 0, 2'd0, 1, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0,
             1, 2'd0, 2'd1, 0, 8'd1);
        tick();

        runBranch("beq_taken", 6'h04, 1'b1, 1'b1, 8'd2);
        runBranch("beq_not_taken", 6'h04, 1'b0, 1'b0, 8'd3);
        runBranch("bne_taken", 6'h05, 1'b0, 1'b1, 8'd4);

        fetchDecode("jal", 6'h03, 6'h10, 8'd5);
        expv("jal_exec", S_JAL, 0, 0, 0, 2'd0, 0, 0, 1, 2'd2, 2'd0, 3'd0, 3'd0,
             1, 2'd2, 2'd2, 0, 8'd5);
        tick();

        fetchDecode("sw", 6'h2B, 6'h00, 8'd6);
        expMemAddr("sw_addr", 8'd6);
        tick();
        expv("sw_write", S_MEM_WR, 1, 1, 1, 2'd0, 1, 0, 0, 2'd0, 2'd1, 3'd2, 3'd0,
             0, 2'd0, 2'd0, 0, 8'd6);
        tick();

        fetchDecode("ori", 6'h0D, 6'h00, 8'd7);
        expv("ori_exec", S_IMM, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd1, 3'd2, 3'd4,
             0, 2'd0, 2'd0, 0, 8'd7);
        tick();
        expv("ori_wb", S_IMM_WB, 0, 0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0, 3'd0, 3'd0,
             1, 2'd0, 2'd0, 0, 8'd7);
        tick();

        // fetch never acknowledged: trap after the 4th waiting cycle
        opcode  = 6'h00;
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expFetch("timeout_wait", 1'b0, 8'd8);
            tick();
        end
        expIdle("timeout_trap", S_TRAP, 1'b1, 8'd8);
        tick();
        expIdle("trap_hold", S_TRAP, 1'b1, 8'd8);
        tick();
        doReset("trap_cleared");

        fetchDecode("illegal_op", 6'h3F, 6'h00, 8'd0);
        expIdle("illegal_op_trap", S_TRAP, 1'b1, 8'd0);
        tick();
        doReset("illegal_op_cleared");

        fetchDecode("bad_funct", 6'h00, 6'h01, 8'd0);
        expIdle("bad_funct_trap", S_TRAP, 1'b1, 8'd0);
        tick();
        doReset("bad_funct_cleared");

        // reset while a store is waiting
        runAdd("add2", 8'd0);
        fetchDecode("sw2", 6'h2B, 6'h00, 8'd1);
        expMemAddr("sw2_addr", 8'd1);
        tick();
        mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            expv("sw2_wait", S_MEM_WR, 1, 1, 1, 2'd0, 1, 0, 0, 2'd0, 2'd1, 3'd2, 3'd0,
                 0, 2'd0, 2'd0, 0, 8'd1);
            tick();
        end
        rst = 1'b0;
        tick();
        expIdle("store_abort", S_FETCH, 1'b0, 8'd0);
        tick();
        repeat (2) tick();

        while (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL %s got=<not observed> want=%h", name_q.pop_front(), exp_q.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle control FSM for the next-generation MIPS core. Instructions and data share one memory port, with a req/ack handshake and variable wait states.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction and drives the datapath muxes, register-file write and PC write.
- Traps on illegal opcodes and on memory timeouts.
- Counts retired instructions.
- Sits between the IR/zero-flag outputs of the multicycle datapath and its control inputs. The existing ALU control unit keeps decoding alu_op plus funct.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay unacknowledged before trap; legal range 1..255.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, combinational in the current cycle
mem_ack  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  store when 1
iord  out  1  0 = address from PC, 1 = address from ALUOut
sig_size  out  2  0 word, 1 half, 2 byte
ext_type  out  1  1 sign-extend, 0 zero-extend (immediate and load data)
ir_we  out  1  latch instruction
pc_we  out  1  write PC
pc_src  out  2  0 ALU result, 1 ALUOut reg, 2 jump target, 3 rs
alu_src_a  out  2  0 PC, 1 rs, 2 zero
alu_src_b  out  3  0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2, 4 imm<<16
alu_op  out  3  ALU op class (package encoding)
reg_we  out  1  register-file write
reg_dst  out  2  0 rt, 1 rd, 2 r31
wb_sel  out  2  0 ALUOut, 1 MDR, 2 PC
trap  out  1  sticky error flag
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - When rst=0 at a clk edge: state=FETCH, trap=0, instret=0, timeout counter=0.
  - All strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are 0 during and immediately after reset. Mux selects are 0.
  - Reset mid-access abandons the access; mem_req drops in the cycle after the edge.
- Handshake:
  - mem_req, mem_we, iord and sig_size stay stable while waiting.
  - An access completes in the cycle mem_ack=1; zero-wait completion in the first request cycle is legal.
  - mem_ack with mem_req=0 is ignored.
- Timeout:
  - The counter increments for each waiting cycle with mem_ack=0 and clears when the access completes.
  - When the counter reaches MEM_TIMEOUT, the FSM goes to TRAP.
- States and transitions:
  - FETCH: mem_req, iord=0, a=PC, b=4, alu_op=ADD. ir_we and pc_we (pc_src=0) are gated by mem_ack (Mealy); advance to DECODE on ack.
  - DECODE: a=PC, b=imm<<2, ADD, so the branch target lands in ALUOut. Dispatch on opcode; an undefined opcode, or an R-type with undefined funct, goes to TRAP.
  - RTYPE: a=rs, b=rt, alu_op=RTYPE, then ALU_WB (reg_we, reg_dst=rd, wb_sel=ALUOut).
  - funct 0x08 (jr) goes to JR instead: pc_we, pc_src=3.
  - IMM (0x08-0x0E): a=rs, b=ext imm, alu_op per opcode, then IMM_WB (reg_we, reg_dst=rt).
    - ext_type=1 for addi/addiu/slti/sltiu; ext_type=0 for andi/ori/xori.
  - LUI (0x0F): a=zero, b=imm<<16, ADD, then IMM_WB.
  - MEM_ADDR: a=rs, b=ext imm, ADD.
    - Loads (0x20,0x21,0x23,0x24,0x25) go to MEM_RD: iord=1, wait for ack, then MEM_WB (reg_we, reg_dst=rt, wb_sel=MDR).
    - Stores (0x28,0x29,0x2B) go to MEM_WR: mem_we=1, iord=1; complete on ack.
    - sig_size/ext_type follow the opcode: lbu/lhu zero-extend.
  - BRANCH (0x04/0x05): a=rs, b=rt, SUB; pc_we=(beq & zero)|(bne & ~zero), pc_src=1.
  - JUMP (0x02): pc_we, pc_src=2.
  - JAL (0x03): additionally reg_we, reg_dst=2, wb_sel=PC (PC already holds PC+4).
  - Every terminal state returns to FETCH.
  - TRAP: absorbing; trap=1 and all strobes are 0 until reset.
- instret:
  - Increments by 1 on the final cycle of each instruction: a WB state, JR, JUMP, JAL, BRANCH (taken or not), or store ack.
  - Wraps modulo 2^CNT_W.
  - Does not increment on trap.
- alu_op during the memory-wait states holds the value of the preceding state, so ALUOut stays unchanged.

Decomposition:
- Package mips_mc_pkg holds:
  - State enum.
  - Opcode and funct constants.
  - alu_op encoding: 0 ADD, 1 SUB, 2 RTYPE, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLTU.
  - pc_src, alu_src and wb_sel encodings.
- One sub-module, mips_mc_memwait: timeout counter plus handshake-complete/timeout flags, shared by FETCH/MEM_RD/MEM_WR.

Test Plan:
- Release reset, mem_ack held 1, IR=0x012A4020 (add): FETCH, DECODE, RTYPE, ALU_WB, back to FETCH; reg_we=1 with reg_dst=1 in cycle 4; instret=1.
- lw (0x8D090004) with mem_ack low for 3 cycles in MEM_RD: mem_req and iord=1 held stable for 4 cycles; MEM_WB wb_sel=1; instret increments once.
- beq with zero=1, then beq with zero=0: pc_we=1/pc_src=1 in the first BRANCH cycle, pc_we=0 in the second; instret increments in both.
- jal 0x0C000010: JAL state asserts pc_we, pc_src=2, reg_we, reg_dst=2, wb_sel=2.
- MEM_TIMEOUT=4, mem_ack never asserted in FETCH: trap=1 after the 4th waiting cycle, mem_req=0 thereafter; rst=0 for one edge returns to FETCH with trap=0.
- Opcode 0x3F in DECODE leads to TRAP; separately, rst=0 asserted during MEM_WR: mem_req=0 and state=FETCH in the next cycle, instret=0.
